// File: rtl/bram_stream_writer_pkg.sv
// Shared constants for the port-A BRAM stream writer: geometry, FSM codes and
// the byte-lane convention (webyte bit i enables dia[8i+7:8i], lane 0 = first byte).
package bram_stream_writer_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DEPTH   = 8192;
  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 8 * LANES;
  localparam int unsigned LANE_W  = $clog2(LANES);
  localparam int unsigned COUNT_W = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [LANES-1:0] lane_bit(input logic [LANE_W-1:0] lane);
    lane_bit       = '0;
    lane_bit[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/bram_stream_writer_if.sv
// Byte-stream input and BRAM port-A write bundles used by bram_stream_writer.
interface byte_stream_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

interface bram_port_a_if;
  import bram_stream_writer_pkg::*;

  logic [DATA_W-1:0] dia;
  logic [ADDR_W-1:0] addra;
  logic              cea;
  logic              wea;
  logic [LANES-1:0]  webyte;

  modport master (output dia, output addra, output cea, output wea, output webyte);
  modport slave  (input  dia, input  addra, input  cea, input  wea, input  webyte);
endinterface

// File: rtl/bram_stream_writer_byte_packer.sv
// Little-endian byte packer: collects bytes into a word with a per-lane fill mask.
module bram_byte_packer
  import bram_stream_writer_pkg::*;
(
  input  logic              clk25,
  input  logic              rst,
  input  logic              push,
  input  logic              clear,
  input  logic [7:0]        data,
  output logic [DATA_W-1:0] word,
  output logic [LANES-1:0]  mask,
  output logic              full
);

  logic [LANE_W-1:0] lane;

  // Unfilled lanes stay zero because clear wipes the whole word, not only the mask.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      lane <= '0;
      word <= '0;
      mask <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
      mask <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane == LANE_W'(i)) word[8*i +: 8] <= data;
      end
      mask <= mask | lane_bit(lane);
      lane <= lane + LANE_W'(1);
    end
  end

  // High when the next pushed byte completes the word.
  assign full = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/bram_stream_writer.sv
// Packs a byte stream into 32-bit words and writes them through BRAM port A,
// starting at a programmable word address and stopping at the top of memory.
module bram_stream_writer
  import bram_stream_writer_pkg::*;
(
  input  logic               clk25,
  input  logic               fpga_rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  byte_stream_if.slave       s,
  bram_port_a_if.master      port_a,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [COUNT_W-1:0] words_wr
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dia_q;
  logic              last_seen;

  logic              push;
  logic              pk_clear;
  logic [DATA_W-1:0] pk_word;
  logic [LANES-1:0]  pk_mask;
  logic              pk_full;

  assign push     = (state == ST_FILL) && s.s_valid;
  assign pk_clear = ((state == ST_IDLE) && start) || (state == ST_WRITE);

  bram_byte_packer u_packer (
    .clk25 (clk25),
    .rst   (fpga_rst),
    .push  (push),
    .clear (pk_clear),
    .data  (s.s_data),
    .word  (pk_word),
    .mask  (pk_mask),
    .full  (pk_full)
  );

  always_ff @(posedge clk25 or posedge fpga_rst) begin
    if (fpga_rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      addra_q   <= '0;
      dia_q     <= '0;
      last_seen <= 1'b0;
      overflow  <= 1'b0;
      words_wr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            words_wr  <= '0;
            overflow  <= 1'b0;
            last_seen <= 1'b0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (push && (pk_full || s.s_last)) begin
            last_seen <= s.s_last;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          dia_q    <= pk_word;
          addra_q  <= addr;
          words_wr <= words_wr + COUNT_W'(1);
          if (last_seen) begin
            state <= ST_DONE;
          end else if (addr == ADDR_W'(DEPTH - 1)) begin
            overflow <= 1'b1;
            state    <= ST_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= ST_FILL;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Port-A data/address come straight from the packer during WRITE and are
  // held from shadow registers afterwards so the bus stays quiet between writes.
  assign s.s_ready     = (state == ST_FILL);
  assign port_a.cea    = (state == ST_WRITE);
  assign port_a.wea    = (state == ST_WRITE);
  assign port_a.webyte = (state == ST_WRITE) ? pk_mask : '0;
  assign port_a.dia    = (state == ST_WRITE) ? pk_word : dia_q;
  assign port_a.addra  = (state == ST_WRITE) ? addr    : addra_q;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bram_stream_writer.sv
// Self-checking bench for bram_stream_writer: table vectors, reset abort and randomized transfers.
module tb_bram_stream_writer;

  localparam int TB_DEPTH = 8192;

  logic        clk25 = 1'b0;
  logic        fpga_rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] start_addr = '0;
  logic        busy, done, overflow;
  logic [13:0] words_wr;

  byte_stream_if sif ();
  bram_port_a_if pa ();

  bram_stream_writer dut (
    .clk25      (clk25),
    .fpga_rst   (fpga_rst),
    .start      (start),
    .start_addr (start_addr),
    .s          (sif),
    .port_a     (pa),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .words_wr   (words_wr)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    logic [12:0]  sa;
    int           n;
    logic [127:0] bytes;
    int           gap;
    bit           restart;
    logic [13:0]  exp_words;
    bit           exp_ovf;
    logic [31:0]  exp_w0;
    logic [3:0]   exp_web0;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] xb [64];
  wr_t  wq [$];
  wr_t  exp_q [$];
  int   m_nw, m_acc;
  bit   m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Any port-A activity must be a full write strobe; record every write.
  always @(negedge clk25) begin
    if (pa.cea || pa.wea || pa.webyte != 4'b0000) begin
      chk("wr_cea", 32'(pa.cea), 32'd1);
      chk("wr_wea", 32'(pa.wea), 32'd1);
      if (pa.cea) wq.push_back('{a: pa.addra, d: pa.dia, we: pa.webyte});
    end
  end

  // Expected writes from the transfer rules: words of 4 bytes, little-endian,
  // consecutive addresses, never beyond the last word of memory.
  task automatic model(input int sa, input int n);
    int needed, room;
    wr_t w;
    needed = (n + 3) / 4;
    room   = TB_DEPTH - sa;
    m_nw   = (needed < room) ? needed : room;
    m_ovf  = (needed > room);
    m_acc  = m_ovf ? 4 * m_nw : n;
    exp_q.delete();
    for (int k = 0; k < m_nw; k++) begin
      w.a  = 13'(sa + k);
      w.d  = '0;
      w.we = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          w.d[8*j +: 8] = xb[4*k + j];
          w.we[j]       = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dia"},      pa.dia, 32'd0);
    chk({tag, "_addra"},    32'(pa.addra), 32'd0);
    chk({tag, "_cea"},      32'(pa.cea), 32'd0);
    chk({tag, "_webyte"},   32'(pa.webyte), 32'd0);
    chk({tag, "_s_ready"},  32'(sif.s_ready), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_done"},     32'(done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_words_wr"}, 32'(words_wr), 32'd0);
  endtask

  task automatic run_xfer(input logic [12:0] sa, input int n, input int gap, input bit restart);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit done_seen = 0;
    model(int'(sa), n);
    wq.delete();
    @(negedge clk25);
    start = 1'b1; start_addr = sa; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    @(negedge clk25);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done_seen && cyc < 400) begin
      if (done) begin
        done_seen = 1;
      end else begin
        if (idx < n && $urandom_range(0, 99) >= gap) begin
          sif.s_valid = 1'b1; sif.s_data = xb[idx]; sif.s_last = (idx == n - 1);
        end else begin
          sif.s_valid = 1'b0; sif.s_last = 1'b0;
        end
        start = restart && (cyc == 5);
        if (start) start_addr = sa + 13'h040;
        acc = sif.s_valid && sif.s_ready;
        @(negedge clk25);
        if (acc) idx++;
        cyc++;
      end
    end
    sif.s_valid = 1'b0; sif.s_last = 1'b0; start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    @(negedge clk25);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("words_wr", 32'(words_wr), 32'(m_nw));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("bytes_accepted", 32'(idx), 32'(m_acc));
    chk("write_count", 32'(wq.size()), 32'(m_nw));
    for (int k = 0; k < wq.size() && k < exp_q.size(); k++) begin
      chk($sformatf("wr%0d_addr", k), 32'(wq[k].a), 32'(exp_q[k].a));
      chk($sformatf("wr%0d_data", k), wq[k].d, exp_q[k].d);
      chk($sformatf("wr%0d_webyte", k), 32'(wq[k].we), 32'(exp_q[k].we));
    end
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{13'h0010, 8, 128'h8877665544332211, 0, 0, 14'd2, 0, 32'h44332211, 4'hF};
    tbl[1] = '{13'h0100, 3, 128'hCCBBAA, 0, 0, 14'd1, 0, 32'h00CCBBAA, 4'h7};
    tbl[2] = '{13'h1FFF, 8, 128'h0807060504030201, 0, 0, 14'd1, 1, 32'h04030201, 4'hF};
    tbl[3] = '{13'h0200, 16, 128'h0F0E0D0C0B0A09080706050403020100, 50, 0, 14'd4, 0, 32'h03020100, 4'hF};
    tbl[4] = '{13'h0300, 8, 128'hF8F7F6F5F4F3F2F1, 20, 1, 14'd2, 0, 32'hF4F3F2F1, 4'hF};
    tbl[5] = '{13'h0050, 4, 128'hDDCCBBAA, 0, 0, 14'd1, 0, 32'hDDCCBBAA, 4'hF};
    tbl[6] = '{13'h1FFE, 7, 128'h77665544332211, 0, 0, 14'd2, 0, 32'h44332211, 4'hF};

    sif.s_data = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    #5;
    check_all_zero("reset");
    @(negedge clk25);
    fpga_rst = 1'b0;

    foreach (tbl[i]) begin
      for (int b = 0; b < tbl[i].n; b++) xb[b] = tbl[i].bytes[8*b +: 8];
      run_xfer(tbl[i].sa, tbl[i].n, tbl[i].gap, tbl[i].restart);
      chk($sformatf("tbl%0d_words", i), 32'(words_wr), 32'(tbl[i].exp_words));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      if (wq.size() > 0) begin
        chk($sformatf("tbl%0d_addr0", i), 32'(wq[0].a), 32'(tbl[i].sa));
        chk($sformatf("tbl%0d_w0", i), wq[0].d, tbl[i].exp_w0);
        chk($sformatf("tbl%0d_web0", i), 32'(wq[0].we), 32'(tbl[i].exp_web0));
      end
    end

    // Reset after two bytes of a word: nothing written, everything back to zero.
    wq.delete();
    @(negedge clk25);
    start = 1'b1; start_addr = 13'h0040;
    @(negedge clk25);
    start = 1'b0; sif.s_valid = 1'b1; sif.s_data = 8'hA1; sif.s_last = 1'b0;
    @(negedge clk25);
    sif.s_data = 8'hA2;
    @(negedge clk25);
    sif.s_valid = 1'b0;
    fpga_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    chk("midrst_no_write", 32'(wq.size()), 32'd0);
    @(negedge clk25);
    fpga_rst = 1'b0;
    xb[0] = 8'h10; xb[1] = 8'h20; xb[2] = 8'h30; xb[3] = 8'h40;
    run_xfer(13'h0020, 4, 0, 0);
    if (wq.size() > 0) chk("post_rst_data", wq[0].d, 32'h40302010);

    for (int r = 0; r < 12; r++) begin
      int n;
      logic [12:0] sa;
      n  = $urandom_range(1, 24);
      sa = (r % 2 == 1) ? 13'($urandom_range(TB_DEPTH - 6, TB_DEPTH - 1))
                        : 13'($urandom_range(0, TB_DEPTH - 1));
      for (int b = 0; b < n; b++) xb[b] = 8'($urandom);
      run_xfer(sa, n, $urandom_range(0, 60), (r % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
